pll_clkgen_multi: RTL and testbench

//  Parametrised soft clock generator, successor to the fixed two-output PLL wrapper.

---
 rtl/pll_clkgen_multi_if.sv | 24 ++
 rtl/pll_clkgen_multi.sv | 133 +++++++++++++
 tb/tb_pll_clkgen_multi.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/pll_clkgen_multi_if.sv
// Reconfiguration request channel for pll_clkgen_multi.
//   cfg_valid  request present          cfg_ready  block can accept
//   cfg_chan   target channel           cfg_div    new divide ratio
//   cfg_phase  new phase offset
interface pll_clkgen_multi_if #(
  parameter int CH_W  = 1,
  parameter int CNT_W = 8
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_chan;
  logic [CNT_W-1:0] cfg_div;
  logic [CNT_W-1:0] cfg_phase;

  modport master (
    output cfg_valid, cfg_chan, cfg_div, cfg_phase,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_chan, cfg_div, cfg_phase,
    output cfg_ready
  );
endinterface

// File: rtl/pll_clkgen_multi.sv
// Soft clock generator: NUM_CLKS divided clocks from refclk, each with a
// runtime-programmable divide ratio and phase offset, plus enable strobes.
//   refclk     sole clock (rising edge)     rst        sync, active-high
//   cfg        reconfiguration channel (slave)
//   outclk     registered divided clocks    outclk_en  pulse at each outclk rise
//   locked     all channels aligned and settled
module pll_clkgen_multi #(
  parameter int                         NUM_CLKS    = 2,
  parameter int                         CNT_W       = 8,
  parameter logic [NUM_CLKS*CNT_W-1:0]  DIV_INIT    = {NUM_CLKS{CNT_W'(2)}},
  parameter logic [NUM_CLKS*CNT_W-1:0]  PHASE_INIT  = (NUM_CLKS*CNT_W)'(1) << CNT_W,
  parameter int                         LOCK_CYCLES = 16
) (
  input  logic                  refclk,
  input  logic                  rst,
  pll_clkgen_multi_if.slave     cfg,
  output logic [NUM_CLKS-1:0]   outclk,
  output logic [NUM_CLKS-1:0]   outclk_en,
  output logic                  locked
);

  localparam int SCNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    ST_RST,
    ST_LOAD,
    ST_SETTLE,
    ST_LOCKED
  } state_t;

  state_t state, state_nx;

  logic [CNT_W-1:0]  div [NUM_CLKS];
  logic [CNT_W-1:0]  ph  [NUM_CLKS];
  logic [CNT_W-1:0]  cnt [NUM_CLKS];
  logic [SCNT_W-1:0] scnt;

  logic             cfg_take;
  logic             chan_hit;
  logic [CNT_W-1:0] wdiv;
  logic [CNT_W-1:0] wph;

  function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] d);
    return (d < CNT_W'(2)) ? CNT_W'(2) : d;
  endfunction

  // d must already be clamped
  function automatic logic [CNT_W-1:0] clamp_ph(input logic [CNT_W-1:0] d,
                                                input logic [CNT_W-1:0] p);
    return (p >= d) ? d - CNT_W'(1) : p;
  endfunction

  assign cfg_take = cfg.cfg_valid && cfg.cfg_ready;
  assign wdiv     = clamp_div(cfg.cfg_div);
  assign wph      = clamp_ph(wdiv, cfg.cfg_phase);

  // Out-of-range channel numbers are possible when NUM_CLKS is not a power of two
  always_comb begin
    chan_hit = 1'b0;
    for (int unsigned i = 0; i < NUM_CLKS; i++) begin
      if (32'(cfg.cfg_chan) == i) chan_hit = 1'b1;
    end
  end

  // State register
  always_ff @(posedge refclk) begin
    if (rst) state <= ST_RST;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      ST_RST:    state_nx = ST_LOAD;
      ST_LOAD:   state_nx = ST_SETTLE;
      ST_SETTLE: if (scnt == SCNT_W'(LOCK_CYCLES)) state_nx = ST_LOCKED;
      ST_LOCKED: if (cfg_take && chan_hit) state_nx = ST_LOAD;
      default:   state_nx = ST_RST;
    endcase
  end

  // Status outputs
  always_comb begin
    locked        = (state == ST_LOCKED);
    cfg.cfg_ready = (state == ST_LOCKED);
  end

  // Settle counter: cleared in LOAD, counts LOCK_CYCLES edges in SETTLE
  always_ff @(posedge refclk) begin
    if (rst || state != ST_SETTLE) scnt <= '0;
    else                           scnt <= scnt + SCNT_W'(1);
  end

  // Shadow configuration
  always_ff @(posedge refclk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CLKS; i++) begin
        div[i] <= clamp_div(DIV_INIT[i*CNT_W +: CNT_W]);
        ph[i]  <= clamp_ph(clamp_div(DIV_INIT[i*CNT_W +: CNT_W]),
                           PHASE_INIT[i*CNT_W +: CNT_W]);
      end
    end else if (cfg_take) begin
      for (int unsigned i = 0; i < NUM_CLKS; i++) begin
        if (32'(cfg.cfg_chan) == i) begin
          div[i] <= wdiv;
          ph[i]  <= wph;
        end
      end
    end
  end

  // Channel counters and registered clock/strobe outputs
  always_ff @(posedge refclk) begin
    for (int unsigned i = 0; i < NUM_CLKS; i++) begin
      if (rst || state == ST_RST) begin
        cnt[i]       <= '0;
        outclk[i]    <= 1'b0;
        outclk_en[i] <= 1'b0;
      end else if (state == ST_LOAD) begin
        // (div - ph) mod div, with ph < div guaranteed by clamping
        cnt[i]       <= (ph[i] == '0) ? '0 : div[i] - ph[i];
        outclk[i]    <= 1'b0;
        outclk_en[i] <= 1'b0;
      end else begin
        cnt[i]       <= (cnt[i] >= div[i] - CNT_W'(1)) ? '0 : cnt[i] + CNT_W'(1);
        outclk[i]    <= (cnt[i] < div[i] - (div[i] >> 1));
        outclk_en[i] <= (cnt[i] == '0);
      end
    end
  end

endmodule

// File: tb/tb_pll_clkgen_multi.sv
module tb_pll_clkgen_multi;

  localparam int LOCK = 16;

  logic       refclk;
  logic       rst;
  logic [1:0] outclk;
  logic [1:0] outclk_en;
  logic       locked;
  logic [2:0] outclk3;
  logic [2:0] outclk_en3;
  logic       locked3;

  int checks   = 0;
  int failures = 0;

  pll_clkgen_multi_if #(.CH_W(1), .CNT_W(8)) cfg_if ();
  pll_clkgen_multi_if #(.CH_W(2), .CNT_W(8)) cfg_if3 ();

  pll_clkgen_multi #(
    .NUM_CLKS    (2),
    .CNT_W       (8),
    .DIV_INIT    (16'h0202),
    .PHASE_INIT  (16'h0100),
    .LOCK_CYCLES (LOCK)
  ) dut (
    .refclk    (refclk),
    .rst       (rst),
    .cfg       (cfg_if),
    .outclk    (outclk),
    .outclk_en (outclk_en),
    .locked    (locked)
  );

  pll_clkgen_multi #(
    .NUM_CLKS    (3),
    .CNT_W       (8),
    .DIV_INIT    (24'h020202),
    .PHASE_INIT  (24'h000100),
    .LOCK_CYCLES (LOCK)
  ) dut3 (
    .refclk    (refclk),
    .rst       (rst),
    .cfg       (cfg_if3),
    .outclk    (outclk3),
    .outclk_en (outclk_en3),
    .locked    (locked3)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  // Expected {en, clk} for a channel j edges after the LOAD edge (j >= 1)
  function automatic logic [1:0] ch_exp(input int d, input int p, input int j);
    int c;
    c = (((d - p) % d) + j - 1) % d;
    return {(c == 0), (c < d - d / 2)};
  endfunction

  task automatic send(input logic [0:0] ch, input logic [7:0] d, input logic [7:0] p);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_chan  = ch;
    cfg_if.cfg_div   = d;
    cfg_if.cfg_phase = p;
  endtask

  // Called right after the edge that moved the main DUT into LOAD
  task automatic run_window(input string tag, input int d0, input int p0,
                            input int d1, input int p1, input int nj);
    logic [1:0] e0, e1;
    logic       el;
    tick();
    checks++;
    if (outclk !== 2'b00 || outclk_en !== 2'b00 || locked !== 1'b0 || cfg_if.cfg_ready !== 1'b0) begin
      failures++;
      $display("FAIL %s_load: clk=%b en=%b lock=%b rdy=%b, required 00 00 0 0",
               tag, outclk, outclk_en, locked, cfg_if.cfg_ready);
    end
    for (int j = 1; j <= nj; j++) begin
      tick();
      e0 = ch_exp(d0, p0, j);
      e1 = ch_exp(d1, p1, j);
      el = (j >= LOCK + 1);
      checks++;
      if (outclk !== {e1[0], e0[0]}) begin
        failures++;
        $display("FAIL %s_clk j=%0d: got %b, required %b", tag, j, outclk, {e1[0], e0[0]});
      end
      checks++;
      if (outclk_en !== {e1[1], e0[1]}) begin
        failures++;
        $display("FAIL %s_en j=%0d: got %b, required %b", tag, j, outclk_en, {e1[1], e0[1]});
      end
      checks++;
      if (locked !== el || cfg_if.cfg_ready !== el) begin
        failures++;
        $display("FAIL %s_lock j=%0d: locked=%b ready=%b, required %b",
                 tag, j, locked, cfg_if.cfg_ready, el);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cfg_if.cfg_valid = 1'b0;  cfg_if.cfg_chan = '0;  cfg_if.cfg_div = '0;  cfg_if.cfg_phase = '0;
    cfg_if3.cfg_valid = 1'b0; cfg_if3.cfg_chan = '0; cfg_if3.cfg_div = '0; cfg_if3.cfg_phase = '0;
    repeat (3) tick();
    checks++;
    if (outclk !== 2'b00 || outclk_en !== 2'b00 || locked !== 1'b0 || cfg_if.cfg_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: clk=%b en=%b lock=%b rdy=%b, required 00 00 0 0",
               outclk, outclk_en, locked, cfg_if.cfg_ready);
    end
    rst = 1'b0;
    tick();  // E0: RST -> LOAD
    checks++;
    if (locked !== 1'b0) begin
      failures++;
      $display("FAIL reset_e0_lock: got %b, required 0", locked);
    end
    run_window("defaults", 2, 0, 2, 1, 20);
  endtask

  // dut3 has NUM_CLKS=3, so channel 3 is out of range; dut3 is at j=20 here
  task automatic test_bad_chan();
    logic [2:0] e;
    cfg_if3.cfg_valid = 1'b1;
    cfg_if3.cfg_chan  = 2'd3;
    cfg_if3.cfg_div   = 8'd9;
    cfg_if3.cfg_phase = 8'd4;
    for (int j = 21; j <= 28; j++) begin
      tick();
      cfg_if3.cfg_valid = 1'b0;
      e = (j % 2 == 1) ? 3'b101 : 3'b010;
      checks++;
      if (locked3 !== 1'b1 || cfg_if3.cfg_ready !== 1'b1) begin
        failures++;
        $display("FAIL bad_chan_lock j=%0d: locked=%b ready=%b, required 1 1",
                 j, locked3, cfg_if3.cfg_ready);
      end
      checks++;
      if (outclk3 !== e || outclk_en3 !== e) begin
        failures++;
        $display("FAIL bad_chan_out j=%0d: clk=%b en=%b, required %b %b", j, outclk3, outclk_en3, e, e);
      end
    end
  endtask

  task automatic test_reconfig();
    send(1'b1, 8'd5, 8'd2);
    tick();  // accepted
    cfg_if.cfg_valid = 1'b0;
    checks++;
    if (locked !== 1'b0 || cfg_if.cfg_ready !== 1'b0) begin
      failures++;
      $display("FAIL reconfig_drop: locked=%b ready=%b, required 0 0", locked, cfg_if.cfg_ready);
    end
    run_window("div5ph2", 2, 0, 5, 2, 22);
  endtask

  task automatic test_clamp();
    send(1'b1, 8'd0, 8'd0);
    tick();
    cfg_if.cfg_valid = 1'b0;
    run_window("clamp_div", 2, 0, 2, 0, 20);
    send(1'b1, 8'd4, 8'd7);
    tick();
    cfg_if.cfg_valid = 1'b0;
    run_window("clamp_ph", 2, 0, 4, 3, 20);
  endtask

  task automatic test_rst_mid_settle();
    send(1'b1, 8'd5, 8'd2);
    tick();
    cfg_if.cfg_valid = 1'b0;
    tick();           // LOAD
    repeat (5) tick(); // inside SETTLE
    rst = 1'b1;
    tick();
    checks++;
    if (outclk !== 2'b00 || outclk_en !== 2'b00 || locked !== 1'b0 || cfg_if.cfg_ready !== 1'b0) begin
      failures++;
      $display("FAIL mid_settle_rst: clk=%b en=%b lock=%b rdy=%b, required 00 00 0 0",
               outclk, outclk_en, locked, cfg_if.cfg_ready);
    end
    rst = 1'b0;
    tick();  // E0
    run_window("restored", 2, 0, 2, 1, 20);
  endtask

  // Request raised alongside rst and held: rst drops it, then it waits for LOCKED
  task automatic test_valid_held();
    rst = 1'b1;
    send(1'b1, 8'd3, 8'd0);
    tick();
    rst = 1'b0;
    tick();  // E0
    run_window("held_settle", 2, 0, 2, 1, 17);
    tick();  // first LOCKED edge takes the request
    cfg_if.cfg_valid = 1'b0;
    checks++;
    if (locked !== 1'b0 || cfg_if.cfg_ready !== 1'b0) begin
      failures++;
      $display("FAIL held_accept: locked=%b ready=%b, required 0 0", locked, cfg_if.cfg_ready);
    end
    run_window("held_apply", 2, 0, 3, 0, 20);
  endtask

  initial begin
    test_reset();
    test_bad_chan();
    test_reconfig();
    test_clamp();
    test_rst_mid_settle();
    test_valid_held();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
